// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// ALU (logic/shift/move/arithmetic), HI/LO write requests, and MULT/MULTU/MUL.
// By default the multiply is an iterative 32-cycle shift-add unit that stalls
// the pipeline while busy. Defining MUL_FAST_EN replaces it with a single-cycle
// combinational 32x32 multiply and ties stall_req to NOT_STOP.

package ex_stage_pkg;
  // Result classes (ALU_SEL_BUS)
  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
  localparam logic [2:0] EXE_RES_MUL        = 3'b101;

  // Operation codes (ALU_OP_BUS)
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_CLZ_OP   = 8'b1011_0000;
  localparam logic [7:0] EXE_CLO_OP   = 8'b1011_0001;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;

  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;
endpackage

module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alu_op_i,
  input  logic [2:0]  alu_sel_i,
  input  logic [31:0] operand_1_i,
  input  logic [31:0] operand_2_i,
  input  logic [4:0]  reg_write_addr_i,
  input  logic        reg_write_en_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [4:0]  reg_write_addr_o,
  output logic        reg_write_en_o,
  output logic [31:0] reg_write_data_o,
  output logic        hilo_write_en_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_req
);

  // ---------------------------------------------------------------------------
  // Shared decode and arithmetic helpers
  // ---------------------------------------------------------------------------
  logic        w_is_mul_op;
  logic        w_is_signed_mul;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_add_ovf;
  logic        w_sub_ovf;
  logic [5:0]  w_clz;
  logic [5:0]  w_clo;

  assign w_is_mul_op     = (alu_op_i == EXE_MULT_OP) || (alu_op_i == EXE_MULTU_OP) ||
                           (alu_op_i == EXE_MUL_OP);
  assign w_is_signed_mul = (alu_op_i == EXE_MULT_OP) || (alu_op_i == EXE_MUL_OP);

  assign w_sum     = operand_1_i + operand_2_i;
  assign w_diff    = operand_1_i - operand_2_i;
  assign w_add_ovf = (operand_1_i[31] == operand_2_i[31]) && (w_sum[31]  != operand_1_i[31]);
  assign w_sub_ovf = (operand_1_i[31] != operand_2_i[31]) && (w_diff[31] != operand_1_i[31]);

  // Leading zero / one counts: the highest matching bit seen last wins.
  always_comb begin
    w_clz = 6'd32;
    w_clo = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (operand_1_i[i])  w_clz = 6'(31 - i);
      if (!operand_1_i[i]) w_clo = 6'(31 - i);
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier: w_mul_done marks the cycle the product is written,
  // w_mul_kind_mul selects GPR (MUL) versus HI/LO (MULT/MULTU) destination.
  // ---------------------------------------------------------------------------
  logic [63:0] w_mul_result;
  logic        w_mul_done;
  logic        w_mul_kind_mul;
  logic        w_mul_stall;

`ifdef MUL_FAST_EN
  logic [63:0] w_op1_ext;
  logic [63:0] w_op2_ext;

  assign w_op1_ext      = w_is_signed_mul ? {{32{operand_1_i[31]}}, operand_1_i} : {32'b0, operand_1_i};
  assign w_op2_ext      = w_is_signed_mul ? {{32{operand_2_i[31]}}, operand_2_i} : {32'b0, operand_2_i};
  assign w_mul_result   = w_op1_ext * w_op2_ext;
  assign w_mul_done     = w_is_mul_op;
  assign w_mul_kind_mul = (alu_op_i == EXE_MUL_OP);
  assign w_mul_stall    = NOT_STOP;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  localparam logic [5:0] LAST_ITER = 6'(MUL_CYCLES - 1);

  mul_state_t  r_state;
  mul_state_t  w_state_next;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_neg;
  logic        r_is_mul;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;

  assign w_mag1 = (w_is_signed_mul && operand_1_i[31]) ? (~operand_1_i + 32'd1) : operand_1_i;
  assign w_mag2 = (w_is_signed_mul && operand_2_i[31]) ? (~operand_2_i + 32'd1) : operand_2_i;

  // Next-state and stall decode for the multiplier FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    w_mul_stall  = NOT_STOP;
    case (r_state)
      S_IDLE: begin
        if (w_is_mul_op) begin
          w_state_next = S_BUSY;
          w_mul_stall  = STOP;
        end
      end
      S_BUSY: begin
        w_mul_stall = STOP;
        if (r_cnt == LAST_ITER) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state register; reset forces IDLE, dropping any partial product.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Shift-add datapath: latch magnitudes in IDLE, one multiplier bit per BUSY cycle.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; they are reloaded on every multiply start and only read in BUSY/DONE.
    case (r_state)
      S_IDLE: begin
        if (w_is_mul_op) begin
          r_mcand  <= {32'b0, w_mag1};
          r_mplier <= w_mag2;
          r_acc    <= 64'd0;
          r_cnt    <= 6'd0;
          r_neg    <= w_is_signed_mul && (operand_1_i[31] ^ operand_2_i[31]);
          r_is_mul <= (alu_op_i == EXE_MUL_OP);
        end
      end
      S_BUSY: begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 6'd1;
      end
      default: ;
    endcase
  end

  assign w_mul_result   = r_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_mul_done     = (r_state == S_DONE);
  assign w_mul_kind_mul = r_is_mul;
`endif

  // ---------------------------------------------------------------------------
  // Result select, write-back control and HI/LO requests
  // ---------------------------------------------------------------------------
  // Combinational output mux; reset forces every output low.
  always_comb begin
    reg_write_addr_o = reg_write_addr_i;
    reg_write_en_o   = reg_write_en_i;
    reg_write_data_o = 32'd0;
    hilo_write_en_o  = 1'b0;
    hi_o             = 32'd0;
    lo_o             = 32'd0;
    stall_req        = w_mul_stall;

    case (alu_sel_i)
      EXE_RES_LOGIC: begin
        case (alu_op_i)
          EXE_AND_OP: reg_write_data_o = operand_1_i & operand_2_i;
          EXE_OR_OP:  reg_write_data_o = operand_1_i | operand_2_i;
          EXE_XOR_OP: reg_write_data_o = operand_1_i ^ operand_2_i;
          EXE_NOR_OP: reg_write_data_o = ~(operand_1_i | operand_2_i);
          default:    reg_write_data_o = 32'd0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (alu_op_i)
          EXE_SLL_OP: reg_write_data_o = operand_2_i << operand_1_i[4:0];
          EXE_SRL_OP: reg_write_data_o = operand_2_i >> operand_1_i[4:0];
          EXE_SRA_OP: reg_write_data_o = 32'($signed(operand_2_i) >>> operand_1_i[4:0]);
          default:    reg_write_data_o = 32'd0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (alu_op_i)
          EXE_MFHI_OP:              reg_write_data_o = hi_i;
          EXE_MFLO_OP:              reg_write_data_o = lo_i;
          EXE_MOVN_OP, EXE_MOVZ_OP: reg_write_data_o = operand_1_i;
          default:                  reg_write_data_o = 32'd0;
        endcase
      end
      EXE_RES_ARITHMETIC: begin
        case (alu_op_i)
          EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: reg_write_data_o = w_sum;
          EXE_SUB_OP, EXE_SUBU_OP: reg_write_data_o = w_diff;
          EXE_SLT_OP:  reg_write_data_o = {31'd0, $signed(operand_1_i) < $signed(operand_2_i)};
          EXE_SLTU_OP: reg_write_data_o = {31'd0, operand_1_i < operand_2_i};
          EXE_CLZ_OP:  reg_write_data_o = {26'd0, w_clz};
          EXE_CLO_OP:  reg_write_data_o = {26'd0, w_clo};
          default:     reg_write_data_o = 32'd0;
        endcase
      end
      default: reg_write_data_o = 32'd0;
    endcase

    // Trapping add/sub silently suppress the write on signed overflow.
    if (((alu_op_i == EXE_ADD_OP) || (alu_op_i == EXE_ADDI_OP)) && w_add_ovf) reg_write_en_o = 1'b0;
    if ((alu_op_i == EXE_SUB_OP) && w_sub_ovf)                                reg_write_en_o = 1'b0;

    if (alu_op_i == EXE_MTHI_OP) begin
      hilo_write_en_o = 1'b1;
      hi_o            = operand_1_i;
      lo_o            = lo_i;
    end else if (alu_op_i == EXE_MTLO_OP) begin
      hilo_write_en_o = 1'b1;
      hi_o            = hi_i;
      lo_o            = operand_1_i;
    end

    // Multiply writes only in its completion cycle; never forward early.
    if (w_mul_done) begin
      if (w_mul_kind_mul) begin
        reg_write_data_o = w_mul_result[31:0];
        reg_write_en_o   = reg_write_en_i;
        hilo_write_en_o  = 1'b0;
      end else begin
        reg_write_en_o   = 1'b0;
        hilo_write_en_o  = 1'b1;
        hi_o             = w_mul_result[63:32];
        lo_o             = w_mul_result[31:0];
      end
    end else if (w_is_mul_op) begin
      reg_write_en_o  = 1'b0;
      hilo_write_en_o = 1'b0;
    end

    if (rst) begin
      reg_write_addr_o = 5'd0;
      reg_write_en_o   = 1'b0;
      reg_write_data_o = 32'd0;
      hilo_write_en_o  = 1'b0;
      hi_o             = 32'd0;
      lo_o             = 32'd0;
      stall_req        = NOT_STOP;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage (default iterative multiplier build).
// Expected results are pushed to a scoreboard queue when stimulus is driven and
// popped when the DUT presents the corresponding output.

module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  alu_op_i;
  logic [2:0]  alu_sel_i;
  logic [31:0] operand_1_i;
  logic [31:0] operand_2_i;
  logic [4:0]  reg_write_addr_i;
  logic        reg_write_en_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [4:0]  reg_write_addr_o;
  logic        reg_write_en_o;
  logic [31:0] reg_write_data_o;
  logic        hilo_write_en_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_req;

  ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .alu_op_i         (alu_op_i),
    .alu_sel_i        (alu_sel_i),
    .operand_1_i      (operand_1_i),
    .operand_2_i      (operand_2_i),
    .reg_write_addr_i (reg_write_addr_i),
    .reg_write_en_i   (reg_write_en_i),
    .hi_i             (hi_i),
    .lo_i             (lo_i),
    .reg_write_addr_o (reg_write_addr_o),
    .reg_write_en_o   (reg_write_en_o),
    .reg_write_data_o (reg_write_data_o),
    .hilo_write_en_o  (hilo_write_en_o),
    .hi_o             (hi_o),
    .lo_o             (lo_o),
    .stall_req        (stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
    logic        hwe;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_addr"}, reg_write_addr_o, e.addr);
    check({e.tag, "_we"}, reg_write_en_o, e.we);
    check({e.tag, "_hwe"}, hilo_write_en_o, e.hwe);
    check({e.tag, "_stall"}, stall_req, 0);
    if (e.chk_data) check({e.tag, "_data"}, reg_write_data_o, e.data);
    if (e.hwe) begin
      check({e.tag, "_hi"}, hi_o, e.hi);
      check({e.tag, "_lo"}, lo_o, e.lo);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic we_in);
    alu_op_i         = op;
    alu_sel_i        = sel;
    operand_1_i      = a;
    operand_2_i      = b;
    reg_write_addr_i = addr;
    reg_write_en_i   = we_in;
  endtask

  // Single-cycle op: drive after the edge, sample at the following negedge.
  task automatic run_alu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic we_in,
                         input logic [31:0] exp_data, input logic exp_we, input logic exp_hwe,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(op, sel, a, b, 5'd9, we_in);
    e = '{tag, 5'd9, exp_data, exp_we, exp_hwe, exp_hi, exp_lo, 1'b1};
    sb.push_back(e);
    @(negedge clk);
    compare_out();
  endtask

  // Multiply: expected product comes from a plain 64-bit multiply in the bench.
  task automatic run_mul(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          stall_cycles;
    bit          done;
    if (op == EXE_MULTU_OP) p = {32'd0, a} * {32'd0, b};
    else                    p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(op, (op == EXE_MUL_OP) ? EXE_RES_MUL : EXE_RES_NOP, a, b, 5'd5, op == EXE_MUL_OP);
    if (op == EXE_MUL_OP) e = '{tag, 5'd5, p[31:0], 1'b1, 1'b0, 32'd0, 32'd0, 1'b1};
    else                  e = '{tag, 5'd5, 32'd0, 1'b0, 1'b1, p[63:32], p[31:0], 1'b0};
    sb.push_back(e);
    stall_cycles = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stall_req) begin
        stall_cycles++;
        check({tag, "_early_wr"}, {reg_write_en_o, hilo_write_en_o}, 0);
      end else begin
        done = 1;
        compare_out();
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 0, 1);
      void'(sb.pop_front());
    end
    check({tag, "_stall_cycles"}, stall_cycles, 33);
  endtask

  initial begin
    rst = 1'b1;
    hi_i = 32'hCAFE_BABE;
    lo_i = 32'h1234_5678;
    drive(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd1, 32'd1, 5'd7, 1'b1);

    // Reset: outputs all zero even with a live op presented.
    @(negedge clk);
    check("rst_data", reg_write_data_o, 0);
    check("rst_we", reg_write_en_o, 0);
    check("rst_addr", reg_write_addr_o, 0);
    drive(EXE_MULT_OP, EXE_RES_NOP, 32'd3, 32'd3, 5'd7, 1'b0);
    @(negedge clk);
    check("rst_stall", stall_req, 0);
    check("rst_hwe", hilo_write_en_o, 0);

    // ALU directed vectors
    run_alu("add_ovf",  EXE_ADD_OP,  EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 0, 0, 0, 0);
    run_alu("addu",     EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1, 0, 0, 0);
    run_alu("addi_ok",  EXE_ADDI_OP, EXE_RES_ARITHMETIC, 32'd100, 32'hFFFF_FFF6, 1, 32'd90, 1, 0, 0, 0);
    run_alu("sub_ovf",  EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 0, 0, 0, 0);
    run_alu("subu",     EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1, 0, 0, 0);
    run_alu("sra",      EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1, 32'hF800_0000, 1, 0, 0, 0);
    run_alu("srl",      EXE_SRL_OP,  EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1, 32'h0800_0000, 1, 0, 0, 0);
    run_alu("sll",      EXE_SLL_OP,  EXE_RES_SHIFT, 32'd31, 32'd1, 1, 32'h8000_0000, 1, 0, 0, 0);
    run_alu("clz",      EXE_CLZ_OP,  EXE_RES_ARITHMETIC, 32'h0001_0000, 0, 1, 32'd15, 1, 0, 0, 0);
    run_alu("clz0",     EXE_CLZ_OP,  EXE_RES_ARITHMETIC, 32'h0, 0, 1, 32'd32, 1, 0, 0, 0);
    run_alu("clo",      EXE_CLO_OP,  EXE_RES_ARITHMETIC, 32'hF000_0000, 0, 1, 32'd4, 1, 0, 0, 0);
    run_alu("clo_all",  EXE_CLO_OP,  EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 0, 1, 32'd32, 1, 0, 0, 0);
    run_alu("slt",      EXE_SLT_OP,  EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1, 0, 0, 0);
    run_alu("sltu",     EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1, 0, 0, 0);
    run_alu("nor",      EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0F0F_0000, 32'h00F0_000F, 1, 32'hF000_FFF0, 1, 0, 0, 0);
    run_alu("xor",      EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'hF00F_F00F, 1, 0, 0, 0);
    run_alu("and",      EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00, 1, 0, 0, 0);
    run_alu("mfhi",     EXE_MFHI_OP, EXE_RES_MOVE, 0, 0, 1, 32'hCAFE_BABE, 1, 0, 0, 0);
    run_alu("mflo",     EXE_MFLO_OP, EXE_RES_MOVE, 0, 0, 1, 32'h1234_5678, 1, 0, 0, 0);
    run_alu("movz_off", EXE_MOVZ_OP, EXE_RES_MOVE, 32'hDEAD_BEEF, 32'd5, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    run_alu("nop_sel",  EXE_ADDU_OP, EXE_RES_NOP, 32'd3, 32'd4, 0, 32'd0, 0, 0, 0, 0);
    run_alu("mthi",     EXE_MTHI_OP, EXE_RES_NOP, 32'hAAAA_5555, 0, 0, 32'd0, 0, 1, 32'hAAAA_5555, 32'h1234_5678);

    // A few random ADDU / OR vectors against bench arithmetic
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      run_alu("rand_addu", EXE_ADDU_OP, EXE_RES_ARITHMETIC, a, b, 1, a + b, 1, 0, 0, 0);
      run_alu("rand_or",   EXE_OR_OP,   EXE_RES_LOGIC,      a, b, 1, a | b, 1, 0, 0, 0);
    end

    // Multiplies, back to back
    run_mul("mult_neg",  EXE_MULT_OP,  32'hFFFF_FFFE, 32'd3);
    run_mul("multu_max", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul("mul_lo",    EXE_MUL_OP,   32'h0001_0000, 32'h0001_0000);
    run_mul("mult_min",  EXE_MULT_OP,  32'h8000_0000, 32'h8000_0000);
    run_mul("mul_mix",   EXE_MUL_OP,   32'd12345, 32'hFFFF_FFF9);

    // Reset in BUSY cycle 10, then MTLO
    @(posedge clk);
    #1;
    drive(EXE_MULT_OP, EXE_RES_NOP, 32'd7, 32'd9, 5'd5, 1'b0);
    @(negedge clk);
    check("busy_pre_stall", stall_req, 1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall", stall_req, 0);
    check("midrst_hwe", hilo_write_en_o, 0);
    check("midrst_hi", hi_o, 0);
    check("midrst_lo", lo_o, 0);
    run_alu("mtlo", EXE_MTLO_OP, EXE_RES_NOP, 32'h0000_1234, 0, 0, 32'd0, 0, 1, 32'hCAFE_BABE, 32'h0000_1234);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes decoded ALU op/select, two operands and write-back control, all held in the ID/EX register.
- Produces GPR write-back data and the EX forwarding triple back to decode, plus the HI/LO write request.
- Executes MULT/MULTU/MUL on an iterative shift-add multiplier and raises stall_req while it is busy.

Parameters:
- MUL_CYCLES, 32, number of BUSY iterations (one multiplier bit per cycle); fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- alu_op_i  in  8  `ALU_OP_BUS` operation code (`EXE_*_OP`).
- alu_sel_i  in  3  `ALU_SEL_BUS` result class (`EXE_RES_*`).
- operand_1_i  in  32  rs value or immediate/shift amount.
- operand_2_i  in  32  rt value or immediate.
- reg_write_addr_i  in  5  destination GPR.
- reg_write_en_i  in  1  GPR write request from decode.
- hi_i  in  32  current HI, already forwarded.
- lo_i  in  32  current LO, already forwarded.
- reg_write_addr_o  out  5  destination GPR, also the EX forwarding address.
- reg_write_en_o  out  1  GPR write enable, also the EX forwarding enable.
- reg_write_data_o  out  32  GPR result, also the EX forwarding data.
- hilo_write_en_o  out  1  HI/LO write request.
- hi_o  out  32  HI write value.
- lo_o  out  32  LO write value.
- stall_req  out  1  pipeline stall request (`STOP`/`NOT_STOP`).

Behaviour:
- All outputs are combinational from the inputs and the multiplier state.
- While rst=1: every output is 0, and the FSM is forced to IDLE.
- Logic (`EXE_RES_LOGIC`):
  - OR/AND/NOR/XOR are bitwise on operand_1_i and operand_2_i.
- Shift (`EXE_RES_SHIFT`):
  - result = operand_2_i shifted by operand_1_i[4:0].
  - SLL/SRL zero-fill; SRA replicates operand_2_i[31].
- Move (`EXE_RES_MOVE`):
  - MFHI returns hi_i; MFLO returns lo_i.
  - MOVN/MOVZ return operand_1_i; the write enable passes through from decode unchanged.
- Arithmetic (`EXE_RES_ARITHMETIC`):
  - ADD/ADDU/ADDI/ADDIU produce the 32-bit sum; SUB/SUBU produce the difference.
  - SLT is a signed compare; SLTU is unsigned. Result is 1 or 0.
  - CLZ/CLO count leading zeros/ones of operand_1_i; range 0..32 (0x0 gives CLZ=32).
  - ADD/ADDI/SUB: on signed overflow, reg_write_en_o=0. No exception is raised.
- `EXE_RES_NOP` or an unknown select: reg_write_data_o=0.
- reg_write_addr_o always passes through; reg_write_en_o passes through except for the overflow rule above.
- MTHI: hilo_write_en_o=1, hi_o=operand_1_i, lo_o=lo_i.
- MTLO: hilo_write_en_o=1, hi_o=hi_i, lo_o=operand_1_i.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - If alu_op_i is MULT/MULTU/MUL: latch the operand magnitudes (two's-complement absolute value for MULT/MUL, raw for MULTU) and the result sign (op1[31]^op2[31], signed ops only).
    - Clear the 64-bit accumulator and the counter, assert stall_req, go to BUSY.
  - BUSY:
    - Each cycle, add the shifted multiplicand when the current multiplier bit is 1; counter+1; stall_req=1.
    - After MUL_CYCLES iterations go to DONE.
  - DONE:
    - stall_req=0; the signed result is the accumulator negated if the sign is set.
    - MULT/MULTU: hilo_write_en_o=1, hi_o=result[63:32], lo_o=result[31:0].
    - MUL: reg_write_data_o=result[31:0]; no HI/LO write.
    - Go to IDLE unconditionally, so the same held instruction never restarts.
- Latency: 34 cycles from first presentation to the DONE cycle. stall_req is high for exactly 33 cycles.
- Outside DONE, a multiply op drives hilo_write_en_o=0 and reg_write_en_o=0, so there is no premature write or forward.
- Back-to-back multiplies: the second starts in the IDLE cycle after DONE.
- Reset mid-BUSY: FSM returns to IDLE, stall_req drops the same cycle, and the partial result is discarded.
- Inputs change during BUSY (illegal while stalled): they are ignored; only the latched operands are used.

Optional Feature:
- MUL_FAST_EN:
  - Defined: the multiply is a single-cycle combinational 32x32 multiply. FSM and counter are removed, and stall_req is tied to `NOT_STOP`. Results are written on the first cycle of presentation.
  - Undefined: the iterative FSM above is used.

Test Plan:
- ADD op1=0x7FFFFFFF op2=1 -> reg_write_data_o=0x80000000, reg_write_en_o=0. ADDU with the same operands -> reg_write_en_o=1.
- SRA op1=4 op2=0x80000000 -> 0xF8000000. SLL op1=31 op2=1 -> 0x80000000. CLZ 0x00010000 -> 15.
- MULT op1=0xFFFFFFFE(-2) op2=3 -> stall_req high 33 cycles, then a DONE cycle with hilo_write_en_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- MULTU op1=op2=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001 at DONE.
- MUL op1=0x10000 op2=0x10000, reg_write_addr_i=5 -> reg_write_data_o=0 and reg_write_en_o=1 only at DONE, never earlier.
- Assert rst in BUSY cycle 10 -> all outputs 0, stall_req=0 next edge. A following MTLO op1=0x1234 -> hilo_write_en_o=1, lo_o=0x1234.
